// File: rtl/result_checker.sv
// Self-checking stage for the single-cycle computer: compares RegisterOut_0 and
// FLAG_OUT against a preloaded expected-vector table and reports errors/pass.
module result_checker #(
    parameter int          DEPTH     = 19,
    parameter int          AW        = 5,
    parameter logic [31:0] FLAG_MASK = 32'hFFFFFFFF
) (
    input  logic          Clock,
    input  logic          reset,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_reg0,
    input  logic [31:0]   load_flag,
    input  logic [AW:0]   vec_count,
    input  logic          start,
    input  logic [31:0]   dut_reg0,
    input  logic [31:0]   dut_flag,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW:0]   vectornum,
    output logic [31:0]   errors,
    output logic [AW:0]   first_err_idx,
    output logic          mismatch
);

    // Control semantics: start is a one-cycle pulse honoured only in IDLE or
    // DONE; load_en is a write strobe honoured only outside RUN. There is no
    // backpressure: every RUN cycle consumes exactly one DUT sample.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW:0] NO_ERR   = '1;

    state_t        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   vectornum_q, vectornum_d;
    logic [31:0]   errors_q, errors_d;
    logic [AW:0]   first_q, first_d;
    logic          mismatch_q, mismatch_d;

    logic [63:0]   mem_q [DEPTH];
    logic [63:0]   exp_vec;
    logic [AW:0]   clamped_count;
    logic          cmp_fail;

    // Expected-vector table is deliberately not reset so a reset keeps the test.
    always_ff @(posedge Clock) begin
        if (load_en && (state_q != S_RUN) && ({1'b0, load_addr} < DEPTH_W)) begin
            mem_q[load_addr] <= {load_reg0, load_flag};
        end
    end

    assign exp_vec       = mem_q[vectornum_q[AW-1:0]];
    assign clamped_count = (vec_count > DEPTH_W) ? DEPTH_W : vec_count;
    assign cmp_fail      = (dut_reg0 != exp_vec[63:32]) ||
                           ((dut_flag & FLAG_MASK) != (exp_vec[31:0] & FLAG_MASK));

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        vectornum_d = vectornum_q;
        errors_d    = errors_q;
        first_d     = first_q;
        mismatch_d  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    count_d     = clamped_count;
                    vectornum_d = '0;
                    errors_d    = '0;
                    first_d     = NO_ERR;
                    state_d     = (clamped_count == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                vectornum_d = vectornum_q + 1'b1;
                if (cmp_fail) begin
                    mismatch_d = 1'b1;
                    if (errors_q != 32'hFFFFFFFF) begin
                        errors_d = errors_q + 32'd1;
                    end
                    if (first_q == NO_ERR) begin
                        first_d = vectornum_q;
                    end
                end
                if (vectornum_q == (count_q - 1'b1)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            vectornum_q <= '0;
            errors_q    <= '0;
            first_q     <= NO_ERR;
            mismatch_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            vectornum_q <= vectornum_d;
            errors_q    <= errors_d;
            first_q     <= first_d;
            mismatch_q  <= mismatch_d;
        end
    end

    assign busy          = (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign pass          = (state_q == S_DONE) && (errors_q == '0);
    assign vectornum     = vectornum_q;
    assign errors        = errors_q;
    assign first_err_idx = first_q;
    assign mismatch      = mismatch_q;

endmodule

// File: tb/tb_result_checker.sv
// Bench for result_checker: two instances (full flag mask and low-nibble mask)
// share stimulus and are checked against a per-index reference model.
module tb_result_checker;

    localparam int          DEPTH  = 19;
    localparam int          AW     = 5;
    localparam logic [31:0] MASK_A = 32'hFFFFFFFF;
    localparam logic [31:0] MASK_B = 32'h0000000F;

    logic          Clock = 1'b0;
    logic          reset = 1'b1;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [31:0]   load_reg0 = '0;
    logic [31:0]   load_flag = '0;
    logic [AW:0]   vec_count = '0;
    logic          start = 1'b0;
    logic [31:0]   dut_reg0 = '0;
    logic [31:0]   dut_flag = '0;

    logic          a_busy, a_done, a_pass, a_mismatch;
    logic [AW:0]   a_vectornum, a_first;
    logic [31:0]   a_errors;
    logic          b_busy, b_done, b_pass, b_mismatch;
    logic [AW:0]   b_vectornum, b_first;
    logic [31:0]   b_errors;

    int checks = 0;
    int errs   = 0;

    // Reference model: expected table and per-index DUT stimulus.
    logic [31:0] mem_reg0  [DEPTH];
    logic [31:0] mem_flag  [DEPTH];
    logic [31:0] stim_reg0 [DEPTH];
    logic [31:0] stim_flag [DEPTH];

    result_checker #(.DEPTH(DEPTH), .AW(AW), .FLAG_MASK(MASK_A)) dut_a (
        .Clock(Clock), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_reg0(load_reg0), .load_flag(load_flag), .vec_count(vec_count),
        .start(start), .dut_reg0(dut_reg0), .dut_flag(dut_flag),
        .busy(a_busy), .done(a_done), .pass(a_pass), .vectornum(a_vectornum),
        .errors(a_errors), .first_err_idx(a_first), .mismatch(a_mismatch)
    );

    result_checker #(.DEPTH(DEPTH), .AW(AW), .FLAG_MASK(MASK_B)) dut_b (
        .Clock(Clock), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_reg0(load_reg0), .load_flag(load_flag), .vec_count(vec_count),
        .start(start), .dut_reg0(dut_reg0), .dut_flag(dut_flag),
        .busy(b_busy), .done(b_done), .pass(b_pass), .vectornum(b_vectornum),
        .errors(b_errors), .first_err_idx(b_first), .mismatch(b_mismatch)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic busy_e, input logic done_e,
                               input int vn_e, input int ea, input int eb,
                               input logic [AW:0] fa, input logic [AW:0] fb,
                               input logic ma, input logic mb);
        chk({tag, ".a_busy"},  32'(a_busy),      32'(busy_e));
        chk({tag, ".a_done"},  32'(a_done),      32'(done_e));
        chk({tag, ".a_pass"},  32'(a_pass),      32'(done_e && ea == 0));
        chk({tag, ".a_vnum"},  32'(a_vectornum), 32'(vn_e));
        chk({tag, ".a_errs"},  a_errors,         32'(ea));
        chk({tag, ".a_first"}, 32'(a_first),     32'(fa));
        chk({tag, ".a_mm"},    32'(a_mismatch),  32'(ma));
        chk({tag, ".b_busy"},  32'(b_busy),      32'(busy_e));
        chk({tag, ".b_pass"},  32'(b_pass),      32'(done_e && eb == 0));
        chk({tag, ".b_vnum"},  32'(b_vectornum), 32'(vn_e));
        chk({tag, ".b_errs"},  b_errors,         32'(eb));
        chk({tag, ".b_first"}, 32'(b_first),     32'(fb));
        chk({tag, ".b_mm"},    32'(b_mismatch),  32'(mb));
    endtask

    function automatic logic vec_fails(input int k, input logic [31:0] mask);
        return (stim_reg0[k] != mem_reg0[k]) || (((stim_flag[k] ^ mem_flag[k]) & mask) != 32'd0);
    endfunction

    // Called only outside a run; out-of-range addresses leave the table alone.
    task automatic load_vec(input int addr, input logic [31:0] r0, input logic [31:0] fl);
        load_en   = 1'b1;
        load_addr = AW'(addr);
        load_reg0 = r0;
        load_flag = fl;
        @(posedge Clock); #1;
        load_en = 1'b0;
        if (addr < DEPTH) begin
            mem_reg0[addr] = r0;
            mem_flag[addr] = fl;
        end
    endtask

    task automatic set_match();
        for (int i = 0; i < DEPTH; i++) begin
            stim_reg0[i] = mem_reg0[i];
            stim_flag[i] = mem_flag[i];
        end
    endtask

    // inj_kind: 0 none, 1 load to addr 2 mid-run, 2 extra start mid-run, 3 async reset mid-run.
    task automatic run_check(input int vc, input int inj_kind, input int inj_idx);
        int n, ea, eb;
        logic [AW:0] fa, fb;
        logic ma, mb;
        n  = (vc > DEPTH) ? DEPTH : vc;
        ea = 0; eb = 0; fa = '1; fb = '1; ma = 1'b0; mb = 1'b0;
        vec_count = (AW+1)'(vc);
        start = 1'b1;
        @(posedge Clock); #1;
        start = 1'b0;
        if (n == 0) begin
            check_state("zero_cnt", 1'b0, 1'b1, 0, 0, 0, '1, '1, 1'b0, 1'b0);
            return;
        end
        for (int k = 0; k < n; k++) begin
            check_state($sformatf("run%0d", k), 1'b1, 1'b0, k, ea, eb, fa, fb, ma, mb);
            dut_reg0 = stim_reg0[k];
            dut_flag = stim_flag[k];
            if (k == inj_idx) begin
                case (inj_kind)
                    1: begin
                        load_en   = 1'b1;
                        load_addr = AW'(2);
                        load_reg0 = ~mem_reg0[2];
                        load_flag = ~mem_flag[2];
                    end
                    2: begin
                        start     = 1'b1;
                        vec_count = (AW+1)'(3);
                    end
                    3: begin
                        #2 reset = 1'b1;
                        #1 check_state("async_rst", 1'b0, 1'b0, 0, 0, 0, '1, '1, 1'b0, 1'b0);
                        #1 reset = 1'b0;
                        return;
                    end
                    default: ;
                endcase
            end
            @(posedge Clock); #1;
            load_en = 1'b0;
            start   = 1'b0;
            ma = vec_fails(k, MASK_A);
            mb = vec_fails(k, MASK_B);
            if (ma) begin
                if (fa == '1) fa = (AW+1)'(k);
                ea++;
            end
            if (mb) begin
                if (fb == '1) fb = (AW+1)'(k);
                eb++;
            end
        end
        check_state("end", 1'b0, 1'b1, n, ea, eb, fa, fb, ma, mb);
        @(posedge Clock); #1;
        check_state("hold", 1'b0, 1'b1, n, ea, eb, fa, fb, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset values.
        repeat (2) @(posedge Clock);
        #1;
        check_state("reset", 1'b0, 1'b0, 0, 0, 0, '1, '1, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge Clock); #1;

        // Table load: reg0 = i*3, flag = 0; one ignored out-of-range write.
        for (int i = 0; i < DEPTH; i++) load_vec(i, 32'(i * 3), 32'd0);
        load_vec(25, 32'hDEADBEEF, 32'hFFFFFFFF);

        // All-match run.
        set_match();
        run_check(19, 0, -1);

        // reg0 corrupted at indices 4 and 11; restarted from DONE.
        set_match();
        stim_reg0[4]  = stim_reg0[4]  ^ ($urandom | 32'd1);
        stim_reg0[11] = stim_reg0[11] ^ ($urandom | 32'd1);
        run_check(19, 0, -1);

        // Flag bit 8 differences (masked out on instance b), bit 2 at index 0.
        set_match();
        for (int i = 1; i < DEPTH; i++) if ($urandom_range(0, 2) == 0) stim_flag[i] = stim_flag[i] | 32'h100;
        stim_flag[0] = stim_flag[0] | 32'h4;
        run_check(19, 0, -1);

        // Randomized tables, corruptions and counts.
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 5; j++) load_vec($urandom_range(0, DEPTH - 1), $urandom, $urandom);
            set_match();
            for (int i = 0; i < DEPTH; i++) begin
                if ($urandom_range(0, 4) == 0) stim_reg0[i] = stim_reg0[i] ^ (32'd1 << $urandom_range(0, 31));
                if ($urandom_range(0, 3) == 0) stim_flag[i] = stim_flag[i] ^ (32'd1 << $urandom_range(0, 31));
            end
            run_check($urandom_range(1, 25), 0, -1);
        end

        // Boundary counts.
        set_match();
        run_check(0, 0, -1);
        run_check(25, 0, -1);

        // Asynchronous reset at vectornum 7, then a matching restart.
        stim_reg0[1] = ~mem_reg0[1];
        stim_reg0[3] = ~mem_reg0[3];
        run_check(19, 3, 7);
        set_match();
        run_check(19, 0, -1);

        // Load during RUN is dropped; a later matching run confirms the table.
        run_check(19, 1, 0);
        run_check(19, 0, -1);

        // A second start during RUN does not restart or shorten the run.
        run_check(19, 2, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule

// File: doc/result_checker.md
Name: result_checker

Overview:
- Synthesizable self-checking stage directly downstream of single_cycle_computer_all.
- Consumes the computer's RegisterOut_0 and FLAG_OUT each cycle and compares them against a preloaded table of expected values.
- Accumulates an error count, records the first failing vector index, and raises done/pass at the end of the run.
- Replaces the simulation-only check loop so a board build can self-test.

Parameters:
- DEPTH, 19, number of expected-vector entries.
- AW, 5, address width, must satisfy 2^AW >= DEPTH.
- FLAG_MASK, 32'hFFFFFFFF, bits of FLAG_OUT that take part in the compare.

Ports:
- Clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state except the vector memory.
- load_en  in  1  write strobe for the expected-vector memory.
- load_addr  in  AW  memory write address.
- load_reg0  in  32  expected RegisterOut_0 value.
- load_flag  in  32  expected FLAG_OUT value.
- vec_count  in  AW+1  number of vectors to check; sampled on start.
- start  in  1  one-cycle pulse; begins a run.
- dut_reg0  in  32  RegisterOut_0 from the computer.
- dut_flag  in  32  FLAG_OUT from the computer.
- busy  out  1  high while in RUN.
- done  out  1  high in DONE.
- pass  out  1  high in DONE when errors == 0.
- vectornum  out  AW+1  index of the vector currently being compared.
- errors  out  32  mismatch count.
- first_err_idx  out  AW+1  index of the first mismatch; all ones if none.
- mismatch  out  1  registered one-cycle pulse per failing compare.

Behaviour:
- Reset values: FSM in IDLE; busy=0, done=0, pass=0, vectornum=0, errors=0, first_err_idx=all ones, mismatch=0, latched count=0. Memory contents are not reset.
- Memory: DEPTH x 64 bits {reg0, flag}.
  - Synchronous write when load_en=1 and state != RUN.
  - Writes with load_addr >= DEPTH are ignored.
  - Read is combinational, addressed by vectornum.
- FSM:
  - IDLE --start--> RUN. On the transition: latch n = min(vec_count, DEPTH), and clear vectornum, errors, first_err_idx and mismatch.
  - If n == 0, go to DONE instead of RUN, with pass=1.
  - RUN: each rising edge compares the current vector.
    - Mismatch when dut_reg0 != exp_reg0, or (dut_flag & FLAG_MASK) != (exp_flag & FLAG_MASK).
    - On mismatch: errors += 1, saturating at 32'hFFFFFFFF; mismatch=1 on the next cycle; if first_err_idx is all ones, set first_err_idx = vectornum.
    - vectornum increments every RUN cycle. After the compare of index n-1, go to DONE with vectornum=n.
  - DONE: done=1 and pass=(errors==0), both held. start restarts exactly as from IDLE. load_en is accepted.
- Latency:
  - The compare for index k uses the DUT inputs present during the k-th RUN cycle.
  - errors and mismatch reflect that compare one cycle later.
  - done rises on the edge that performs the last compare; errors is final at the same edge.
- Ignored inputs:
  - start while in RUN.
  - load_en while in RUN (memory must not change mid-run).
- Reset asserted mid-run: immediately returns to IDLE with all outputs at reset values. A run is never resumed.
- vec_count > DEPTH is clamped to DEPTH.
- Width rules:
  - vectornum is AW+1 bits so it can hold the value DEPTH.
  - first_err_idx sentinel is all ones of width AW+1.

Test Plan:
- Match run: load 19 vectors with reg0=i*3 and flag=0; drive matching DUT values; start with vec_count=19 → done after 19 RUN cycles, errors=0, pass=1, first_err_idx=6'h3F.
- Injected failures:
  - Corrupt dut_reg0 at indices 4 and 11 → errors=2, first_err_idx=4, exactly two mismatch pulses one cycle after those compares, pass=0.
  - With FLAG_MASK=32'h0000000F, differing only in flag bit 8 gives no error; differing in bit 2 at index 0 gives errors=1 and first_err_idx=0.
- Boundary counts:
  - vec_count=0 → DONE on the next edge with pass=1, errors=0.
  - vec_count=25 → clamped; done with vectornum=19.
- Reset mid-run: assert reset asynchronously at vectornum=7, between clock edges → busy, errors and vectornum go to 0 without waiting for a clock edge. Restart with all vectors matching → pass=1, proving the memory contents were retained.
- Ignored and restart inputs:
  - load_en pulsed during RUN on address 2 → stored value is unchanged after the run.
  - A second start in RUN does not restart the run.
  - A start in DONE reruns and clears errors.
